// File: rtl/bullet_scheduler.sv
// Player-bullet slot pool: spawns at the plane nose on fire, advances once per
// frame on vs_neg, retires on top exit or collision, with a frame cooldown.
module bullet_scheduler #(
  parameter int unsigned NUM_BULLETS   = 4,
  parameter logic [10:0] BULLET_SPEED  = 11'd4,
  parameter logic [3:0]  FIRE_COOLDOWN = 4'd8,
  parameter logic [10:0] NOSE_OFFSET   = 11'd64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fire,
  input  logic                       vs_neg,
  input  logic [10:0]                plane_x,
  input  logic [10:0]                plane_y,
  input  logic [NUM_BULLETS-1:0]     hit_clear,
  output logic [NUM_BULLETS-1:0]     bullet_valid,
  output logic [11*NUM_BULLETS-1:0]  bullet_x,
  output logic [11*NUM_BULLETS-1:0]  bullet_y,
  output logic                       fire_accepted,
  output logic                       cooldown_active
);

  localparam int unsigned CW  = 11;
  localparam int unsigned XYW = CW * NUM_BULLETS;
  localparam int unsigned CDW = 4;

  logic [NUM_BULLETS-1:0] valid_q, valid_d;
  logic [XYW-1:0]         x_q, x_d;
  logic [XYW-1:0]         y_q, y_d;
  logic [CDW-1:0]         cooldown_q, cooldown_d;
  logic                   fire_pending_q, fire_pending_d;
  logic                   fire_accepted_q, fire_accepted_d;
  logic                   cooldown_active_q, cooldown_active_d;
  logic                   spawn_ok;
  logic                   slot_taken;

  // Per-slot move/retire/kill plus lowest-free-slot spawn and cooldown update.
  always_comb begin
    valid_d           = valid_q;
    x_d               = x_q;
    y_d               = y_q;
    cooldown_d        = cooldown_q;
    fire_pending_d    = fire_pending_q | fire;
    fire_accepted_d   = 1'b0;
    slot_taken        = 1'b0;
    spawn_ok          = vs_neg && (fire || fire_pending_q) && (cooldown_q == '0) &&
                        (plane_y >= NOSE_OFFSET) && !(&valid_q);

    for (int i = 0; i < int'(NUM_BULLETS); i++) begin
      if (valid_q[i]) begin
        // A hit wins over movement; the killed slot keeps its last position.
        if (hit_clear[i]) begin
          valid_d[i] = 1'b0;
        end else if (vs_neg) begin
          if (y_q[CW*i +: CW] <= BULLET_SPEED) begin
            valid_d[i] = 1'b0;
          end else begin
            y_d[CW*i +: CW] = y_q[CW*i +: CW] - BULLET_SPEED;
          end
        end
      end else if (spawn_ok && !slot_taken) begin
        slot_taken      = 1'b1;
        valid_d[i]      = 1'b1;
        x_d[CW*i +: CW] = plane_x;
        y_d[CW*i +: CW] = plane_y - NOSE_OFFSET;
      end
    end

    if (vs_neg) begin
      fire_pending_d = 1'b0;
    end

    if (spawn_ok) begin
      cooldown_d      = FIRE_COOLDOWN;
      fire_accepted_d = 1'b1;
    end else if (vs_neg && (cooldown_q != '0)) begin
      cooldown_d = cooldown_q - CDW'(1);
    end

    cooldown_active_d = (cooldown_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q           <= '0;
      x_q               <= '0;
      y_q               <= '0;
      cooldown_q        <= '0;
      fire_pending_q    <= 1'b0;
      fire_accepted_q   <= 1'b0;
      cooldown_active_q <= 1'b0;
    end else begin
      valid_q           <= valid_d;
      x_q               <= x_d;
      y_q               <= y_d;
      cooldown_q        <= cooldown_d;
      fire_pending_q    <= fire_pending_d;
      fire_accepted_q   <= fire_accepted_d;
      cooldown_active_q <= cooldown_active_d;
    end
  end

  assign bullet_valid    = valid_q;
  assign bullet_x        = x_q;
  assign bullet_y        = y_q;
  assign fire_accepted   = fire_accepted_q;
  assign cooldown_active = cooldown_active_q;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Self-checking bench for bullet_scheduler: vector table, frame-loop model and
// hand sequences, all checked through an expected-result queue.
module tb_bullet_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        fire;
  logic        vs_neg;
  logic [10:0] plane_x;
  logic [10:0] plane_y;
  logic [3:0]  hit_clear;
  logic [3:0]  bullet_valid;
  logic [43:0] bullet_x;
  logic [43:0] bullet_y;
  logic        fire_accepted;
  logic        cooldown_active;

  bullet_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .fire            (fire),
    .vs_neg          (vs_neg),
    .plane_x         (plane_x),
    .plane_y         (plane_y),
    .hit_clear       (hit_clear),
    .bullet_valid    (bullet_valid),
    .bullet_x        (bullet_x),
    .bullet_y        (bullet_y),
    .fire_accepted   (fire_accepted),
    .cooldown_active (cooldown_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rb;
    bit          f;
    bit          vs;
    logic [10:0] py;
    logic [3:0]  hit;
    logic [3:0]  ev;
    bit          efa;
    bit          ecd;
    int          slot;
    logic [10:0] ex;
    logic [10:0] ey;
  } vec_t;

  typedef struct {
    int          id;
    logic [3:0]  ev;
    bit          efa;
    bit          ecd;
    int          slot;
    logic [10:0] ex;
    logic [10:0] ey;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[14];
  int   total = 0;
  int   bad   = 0;
  int   step_id = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rb, bit f, bit vs, logic [10:0] py, logic [3:0] hit,
                              logic [3:0] ev, bit efa, bit ecd, int slot,
                              logic [10:0] ex, logic [10:0] ey);
    vec_t v;
    v.rb = rb; v.f = f; v.vs = vs; v.py = py; v.hit = hit;
    v.ev = ev; v.efa = efa; v.ecd = ecd; v.slot = slot; v.ex = ex; v.ey = ey;
    return v;
  endfunction

  task automatic do_reset();
    fire = 1'b0; vs_neg = 1'b0; hit_clear = 4'd0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    exp_t g;
    if (v.rb) do_reset();
    fire = v.f; vs_neg = v.vs; plane_x = 11'd400; plane_y = v.py; hit_clear = v.hit;
    e.id = step_id; e.ev = v.ev; e.efa = v.efa; e.ecd = v.ecd;
    e.slot = v.slot; e.ex = v.ex; e.ey = v.ey;
    sb.push_back(e);
    @(posedge clk); #1;
    g = sb.pop_front();
    cmp($sformatf("s%0d valid", g.id), 64'(bullet_valid), 64'(g.ev));
    cmp($sformatf("s%0d fire_accepted", g.id), 64'(fire_accepted), 64'(g.efa));
    cmp($sformatf("s%0d cooldown_active", g.id), 64'(cooldown_active), 64'(g.ecd));
    cmp($sformatf("s%0d x[%0d]", g.id, g.slot), 64'(bullet_x[11*g.slot +: 11]), 64'(g.ex));
    cmp($sformatf("s%0d y[%0d]", g.id, g.slot), 64'(bullet_y[11*g.slot +: 11]), 64'(g.ey));
    step_id++;
  endtask

  // Fire level f held over frames first..last; spawns land every 9 frames until the pool is full.
  task automatic run_frames(input int first, input int last, input bit f);
    for (int k = first; k <= last; k++) begin
      int          last_sp;
      int          nsp;
      logic [3:0]  ev;
      bit          fa;
      bit          cd;
      logic [10:0] y;
      last_sp = (k / 9) * 9;
      if (last_sp > 27) last_sp = 27;
      nsp = k / 9 + 1;
      if (nsp > 4) nsp = 4;
      ev = 4'((1 << nsp) - 1);
      fa = f && (k % 9 == 0) && (k <= 27);
      cd = (k - last_sp) < 8;
      y  = 11'(448 - 4 * k);
      apply(mk(1'b0, f, 1'b1, 11'd512, 4'd0, ev, fa, cd, 0, 11'd400, y));
      apply(mk(1'b0, f, 1'b0, 11'd512, 4'd0, ev, 1'b0, cd, 0, 11'd400, y));
    end
  endtask

  task automatic check_all_zero(input string nm);
    cmp({nm, " valid"}, 64'(bullet_valid), 64'd0);
    cmp({nm, " x"}, 64'(bullet_x), 64'd0);
    cmp({nm, " y"}, 64'(bullet_y), 64'd0);
    cmp({nm, " fire_accepted"}, 64'(fire_accepted), 64'd0);
    cmp({nm, " cooldown_active"}, 64'(cooldown_active), 64'd0);
  endtask

  initial begin
    fire = 1'b0; vs_neg = 1'b0; hit_clear = 4'd0;
    plane_x = 11'd400; plane_y = 11'd512;
    rst = 1'b1;
    #2;
    check_all_zero("reset");

    // rb f vs py hit | valid fa cd slot x y
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 11'd512, 4'd0, 4'b0000, 1'b0, 1'b0, 0, 11'd0,   11'd0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 11'd512, 4'd0, 4'b0000, 1'b0, 1'b0, 0, 11'd0,   11'd0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 11'd512, 4'd0, 4'b0000, 1'b0, 1'b0, 0, 11'd0,   11'd0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 11'd512, 4'd0, 4'b0001, 1'b1, 1'b1, 0, 11'd400, 11'd448);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 11'd512, 4'd0, 4'b0001, 1'b0, 1'b1, 0, 11'd400, 11'd448);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1, 11'd512, 4'd0, 4'b0001, 1'b0, 1'b1, 0, 11'd400, 11'd444);
    tbl[6]  = mk(1'b1, 1'b1, 1'b1, 11'd68,  4'd0, 4'b0001, 1'b1, 1'b1, 0, 11'd400, 11'd4);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 11'd68,  4'd0, 4'b0000, 1'b0, 1'b1, 0, 11'd400, 11'd4);
    tbl[8]  = mk(1'b1, 1'b1, 1'b1, 11'd63,  4'd0, 4'b0000, 1'b0, 1'b0, 0, 11'd0,   11'd0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 11'd63,  4'd0, 4'b0000, 1'b0, 1'b0, 0, 11'd0,   11'd0);
    tbl[10] = mk(1'b1, 1'b1, 1'b1, 11'd64,  4'd0, 4'b0001, 1'b1, 1'b1, 0, 11'd400, 11'd0);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, 11'd64,  4'd0, 4'b0000, 1'b0, 1'b1, 0, 11'd400, 11'd0);
    tbl[12] = mk(1'b1, 1'b1, 1'b1, 11'd512, 4'd1, 4'b0001, 1'b1, 1'b1, 0, 11'd400, 11'd448);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 11'd512, 4'd1, 4'b0000, 1'b0, 1'b1, 0, 11'd400, 11'd448);
    for (int i = 0; i < 14; i++) apply(tbl[i]);

    // Continuous fire: spawns on frames 0, 9, 18, then hit_clear cases.
    do_reset();
    run_frames(0, 19, 1'b1);
    apply(mk(1'b0, 1'b0, 1'b0, 11'd512, 4'b0010, 4'b0101, 1'b0, 1'b1, 1, 11'd400, 11'd408));
    apply(mk(1'b0, 1'b0, 1'b1, 11'd512, 4'b0001, 4'b0100, 1'b0, 1'b1, 0, 11'd400, 11'd372));
    apply(mk(1'b0, 1'b0, 1'b0, 11'd512, 4'b0000, 4'b0100, 1'b0, 1'b1, 2, 11'd400, 11'd440));

    // Fill the pool, drain cooldown, then pool-full suppression and refill.
    do_reset();
    run_frames(0, 27, 1'b1);
    run_frames(28, 35, 1'b0);
    apply(mk(1'b0, 1'b1, 1'b0, 11'd512, 4'b0000, 4'b1111, 1'b0, 1'b0, 0, 11'd400, 11'd308));
    apply(mk(1'b0, 1'b0, 1'b1, 11'd512, 4'b0000, 4'b1111, 1'b0, 1'b0, 0, 11'd400, 11'd304));
    apply(mk(1'b0, 1'b0, 1'b0, 11'd512, 4'b0001, 4'b1110, 1'b0, 1'b0, 0, 11'd400, 11'd304));
    apply(mk(1'b0, 1'b0, 1'b1, 11'd512, 4'b0000, 4'b1110, 1'b0, 1'b0, 0, 11'd400, 11'd304));
    apply(mk(1'b0, 1'b1, 1'b1, 11'd512, 4'b0000, 4'b1111, 1'b1, 1'b1, 0, 11'd400, 11'd448));

    // Mid-frame async reset with live bullets and a pending shot.
    apply(mk(1'b0, 1'b1, 1'b0, 11'd512, 4'b0000, 4'b1111, 1'b0, 1'b1, 0, 11'd400, 11'd448));
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("midframe_rst");
    #2;
    rst = 1'b0;
    apply(mk(1'b0, 1'b0, 1'b1, 11'd512, 4'b0000, 4'b0000, 1'b0, 1'b0, 0, 11'd0, 11'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bullet_scheduler.md
Name: bullet_scheduler

Overview:
- Owns a fixed pool of player-bullet slots for the VGA plane game.
- Accepts the fire button and allocates a free slot at the plane's nose.
- Advances every live bullet upward once per frame, on the vs_neg frame strobe, so sprite positions never change mid-scan.
- Retires bullets that leave the top of the screen or that collision logic reports as hit. Enforces a per-frame fire cooldown.

Parameters:
NUM_BULLETS, 4, number of bullet slots (1..8)
BULLET_SPEED, 11'd4, pixels moved upward per frame
FIRE_COOLDOWN, 4'd8, frames loaded into cooldown counter on each spawn
NOSE_OFFSET, 11'd64, spawn y distance above plane centre (plane half height)

Ports:
clk  in  1  system clock
rst  in  1  reset
fire  in  1  fire button level, synchronous to clk
vs_neg  in  1  one-cycle pulse per frame (vertical sync falling edge)
plane_x  in  11  player plane centre x (already frame-latched)
plane_y  in  11  player plane centre y (already frame-latched)
hit_clear  in  NUM_BULLETS  per-slot kill request from collision logic
bullet_valid  out  NUM_BULLETS  slot i holds a live bullet
bullet_x  out  11*NUM_BULLETS  slot i x at bits [11*i+10:11*i]
bullet_y  out  11*NUM_BULLETS  slot i y, same packing
fire_accepted  out  1  one-cycle pulse: a bullet was spawned
cooldown_active  out  1  cooldown counter nonzero

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk. On rst all of the following clear to 0: bullet_valid, bullet_x, bullet_y, fire_accepted, the cooldown counter (so cooldown_active=0) and fire_pending. An rst assertion mid-frame discards all bullets and any pending shot.
- All state is registered. Outputs reflect a vs_neg event on the cycle after the strobe (latency 1).
- fire_pending: set on any cycle with fire=1. Cleared on every vs_neg cycle, whether or not a spawn happens. Shots never queue across frames.
- Effective fire request on a vs_neg cycle = fire | fire_pending.
- Move/retire, on a vs_neg cycle, for each slot that is valid at the start of the cycle:
  - if y <= BULLET_SPEED, clear valid;
  - else y <= y - BULLET_SPEED.
  - x never changes after spawn.
- Spawn, on a vs_neg cycle, allowed only when all hold:
  - effective request = 1;
  - cooldown == 0;
  - plane_y >= NOSE_OFFSET;
  - at least one slot is invalid at the start of the cycle.
  - Slots retired in the same cycle are not reusable until the next frame.
- Spawn target: lowest-index free slot. Sets valid=1, x=plane_x, y=plane_y-NOSE_OFFSET, with no movement applied that frame.
- Cooldown: on spawn, load FIRE_COOLDOWN. On any other vs_neg with cooldown>0, decrement by 1. Saturates at 0 and holds between vs_neg strobes. Minimum spacing between spawns is FIRE_COOLDOWN+1 frames.
- A suppressed spawn (pool full, plane_y < NOSE_OFFSET, or cooldown) leaves the cooldown counter following the decrement rule only, and produces no fire_accepted.
- fire_accepted: registered, 1 for exactly one cycle following a spawning vs_neg cycle.
- hit_clear, evaluated on any cycle:
  - For each set bit whose slot is valid at the start of the cycle, clear valid next cycle. This takes priority over move in the same vs_neg cycle.
  - Bits for invalid slots are ignored; a spawn into that slot in the same cycle proceeds.
  - x/y of a killed slot hold their last values.
- Arithmetic: 11-bit unsigned throughout. The retire and suppress comparisons guarantee no underflow wrap.
- States per slot: FREE -> LIVE (spawn) -> FREE (top exit or hit_clear). The global cooldown counter acts as a separate frame-domain down-counter.

Test Plan:
- Spawn: plane (400,512), fire held 3 cycles mid-frame, then vs_neg -> slot0 valid, x=400, y=448; fire_accepted high one cycle; cooldown_active=1. Next vs_neg -> y=444.
- Cooldown: fire held continuously, vs_neg every frame -> spawns on frames 0, 9 and 18 into slots 0, 1, 2. fire_accepted pulses only on those frames; cooldown_active low only during frame 8→9 and frame 17→18 gaps.
- Top exit: plane_y=68 spawns y=4 -> next vs_neg clears valid[0]. Retest with plane_y=63 -> no spawn, fire_accepted=0, cooldown_active stays 0.
- Pool full: 4 slots live, cooldown 0, fire pulse -> no spawn, fire_pending cleared. A fire pulse is needed again the following frame once a slot frees.
- hit_clear=4'b0010 on a non-vs_neg cycle with slots 0–1 live -> valid becomes 4'b0001 next cycle, slot1 x/y unchanged. hit_clear on the same cycle as vs_neg -> slot removed, not moved.
- rst pulsed mid-frame with 3 live bullets and fire_pending=1 -> all outputs 0 immediately; next vs_neg without fire spawns nothing.
